// File: rtl/io_fabric_if.sv
// CPU-side bus and peripheral-slot bus of the I/O fabric, grouped so the
// fabric and its environment connect through one port each.
// slave  : the fabric itself.
// master : the CPU plus attached peripherals (the bench drives this side).
// Writes take effect on the rising clock edge on which dwrite_en is nonzero.
// Reads are addressed in one cycle; dread_data holds the result after the
// next rising edge. There is no stall or backpressure in either direction.
interface io_fabric_if #(
    parameter int NUM_SLOTS = 4,
    parameter int NUM_IRQ   = 8
);
    logic [15:0]            dread_addr;
    logic [15:0]            dread_data;
    logic [15:0]            dwrite_addr;
    logic [15:0]            dwrite_data;
    logic [1:0]             dwrite_en;
    logic [2*NUM_SLOTS-1:0] slot_wr_en;
    logic [7:0]             slot_wr_off_even;
    logic [7:0]             slot_wr_off_odd;
    logic [15:0]            slot_wr_data;
    logic [7:0]             slot_rd_off_even;
    logic [7:0]             slot_rd_off_odd;
    logic [8*NUM_SLOTS-1:0] slot_rd_even;
    logic [8*NUM_SLOTS-1:0] slot_rd_odd;
    logic [NUM_IRQ-1:0]     irq_in;
    logic                   interrupt;

    modport slave (
        input  dread_addr, dwrite_addr, dwrite_data, dwrite_en,
        input  slot_rd_even, slot_rd_odd, irq_in,
        output dread_data, slot_wr_en, slot_wr_off_even, slot_wr_off_odd,
        output slot_wr_data, slot_rd_off_even, slot_rd_off_odd, interrupt
    );

    modport master (
        output dread_addr, dwrite_addr, dwrite_data, dwrite_en,
        output slot_rd_even, slot_rd_odd, irq_in,
        input  dread_data, slot_wr_en, slot_wr_off_even, slot_wr_off_odd,
        input  slot_wr_data, slot_rd_off_even, slot_rd_off_odd, interrupt
    );
endinterface

// File: rtl/io_fabric.sv
// I/O fabric front end: splits CPU byte-pair accesses into an even and an
// odd byte lane, decodes each lane to a peripheral slot, registers read data
// and hosts the interrupt controller in slot 0.
module io_fabric #(
    parameter logic [15:0]        IOBASE    = 16'h0010,
    parameter int                 SLOT_SIZE = 8,
    parameter int                 NUM_SLOTS = 4,
    parameter int                 NUM_IRQ   = 8,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE  = {NUM_IRQ{1'b1}}
) (
    input  logic        clk,
    input  logic        reset,
    io_fabric_if.slave  bus
);
    localparam int          OFF_W = $clog2(SLOT_SIZE);
    localparam logic [16:0] SPAN  = 17'(NUM_SLOTS * SLOT_SIZE);
    localparam logic [16:0] OMASK = 17'(SLOT_SIZE - 1);

    typedef struct packed {
        logic       hit;
        logic [3:0] slot;
        logic [7:0] off;   // word-aligned byte offset within the slot
    } lane_dec_t;

    // A lane below IOBASE wraps to a 17-bit value with bit 16 set, so a
    // single unsigned compare against SPAN covers both bounds.
    function automatic lane_dec_t decode(input logic [15:0] lane);
        lane_dec_t   d;
        logic [16:0] rel;
        rel    = {1'b0, lane} - {1'b0, IOBASE};
        d.hit  = (rel < SPAN);
        d.slot = 4'(rel >> OFF_W);
        d.off  = 8'(rel & OMASK) & 8'hFE;
        return d;
    endfunction

    logic [15:0] rd_even_addr, rd_odd_addr, wr_even_addr, wr_odd_addr;
    logic        wr_even_en, wr_odd_en;
    logic [7:0]  wr_even_byte, wr_odd_byte;
    lane_dec_t   rd_even_dec, rd_odd_dec, wr_even_dec, wr_odd_dec;

    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
    logic               armed_q, armed_d;
    logic               interrupt_q, interrupt_d;
    logic [15:0]        dread_data_q, dread_data_d;

    logic [NUM_IRQ-1:0] pend_eff, active;
    logic [15:0]        enable16, pend16, vector16;
    logic [7:0]         rd_even_byte, rd_odd_byte;

    // Lane split: the even lane of an odd address is the next word.
    always_comb begin
        rd_even_addr = {dread_addr_hi_inc(bus.dread_addr), 1'b0};
        rd_odd_addr  = {bus.dread_addr[15:1], 1'b1};
        wr_even_addr = {dread_addr_hi_inc(bus.dwrite_addr), 1'b0};
        wr_odd_addr  = {bus.dwrite_addr[15:1], 1'b1};
        if (bus.dwrite_addr[0]) begin
            wr_even_en   = bus.dwrite_en[1];
            wr_odd_en    = bus.dwrite_en[0];
            wr_even_byte = bus.dwrite_data[15:8];
            wr_odd_byte  = bus.dwrite_data[7:0];
        end else begin
            wr_even_en   = bus.dwrite_en[0];
            wr_odd_en    = bus.dwrite_en[1];
            wr_even_byte = bus.dwrite_data[7:0];
            wr_odd_byte  = bus.dwrite_data[15:8];
        end
        rd_even_dec = decode(rd_even_addr);
        rd_odd_dec  = decode(rd_odd_addr);
        wr_even_dec = decode(wr_even_addr);
        wr_odd_dec  = decode(wr_odd_addr);
    end

    // Upper 15 address bits, bumped by one for odd addresses (wraps at 64K).
    function automatic logic [14:0] dread_addr_hi_inc(input logic [15:0] a);
        return a[15:1] + 15'(a[0]);
    endfunction

    // Write strobes and lane-normalised data toward the peripheral slots.
    always_comb begin
        bus.slot_wr_en = '0;
        for (int s = 1; s < NUM_SLOTS; s++) begin
            bus.slot_wr_en[2*s]   = wr_even_en && wr_even_dec.hit && (wr_even_dec.slot == 4'(s));
            bus.slot_wr_en[2*s+1] = wr_odd_en && wr_odd_dec.hit && (wr_odd_dec.slot == 4'(s));
        end
        bus.slot_wr_off_even = wr_even_dec.off;
        bus.slot_wr_off_odd  = wr_odd_dec.off;
        bus.slot_wr_data     = {wr_odd_byte, wr_even_byte};
        bus.slot_rd_off_even = rd_even_dec.off;
        bus.slot_rd_off_odd  = rd_odd_dec.off;
    end

    // Interrupt controller next state and register views.
    always_comb begin
        logic [15:0] en_w, clr_w;
        logic [3:0]  idx;
        logic        we_even0, we_odd0;
        we_even0 = wr_even_en && wr_even_dec.hit && (wr_even_dec.slot == 4'd0);
        we_odd0  = wr_odd_en && wr_odd_dec.hit && (wr_odd_dec.slot == 4'd0);
        en_w     = 16'(enable_q);
        clr_w    = '0;
        if (we_even0 && wr_even_dec.off == 8'd0) en_w[7:0]   = wr_even_byte;
        if (we_odd0  && wr_odd_dec.off  == 8'd0) en_w[15:8]  = wr_odd_byte;
        if (we_even0 && wr_even_dec.off == 8'd2) clr_w[7:0]  = wr_even_byte;
        if (we_odd0  && wr_odd_dec.off  == 8'd2) clr_w[15:8] = wr_odd_byte;
        enable_d = en_w[NUM_IRQ-1:0];
        // Set wins over a same-cycle clear; no edges are seen until the
        // sample register has been loaded once after reset.
        pending_d = ((pending_q & ~clr_w[NUM_IRQ-1:0]) |
                     (bus.irq_in & ~irq_prev_q & {NUM_IRQ{armed_q}})) & IRQ_EDGE;
        irq_prev_d = bus.irq_in;
        armed_d    = 1'b1;

        pend_eff = (pending_q & IRQ_EDGE) | (bus.irq_in & ~IRQ_EDGE);
        active   = pend_eff & enable_q;
        idx      = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) idx = 4'(i);
        end
        interrupt_d = |active;
        enable16    = 16'(enable_q);
        pend16      = 16'(pend_eff);
        vector16    = {8'h00, |active, 3'b000, idx};
    end

    // Per-lane read source: slot 0 registers, peripheral bytes, or a
    // same-cycle write to the very same byte address.
    always_comb begin
        rd_even_byte = 8'h00;
        rd_odd_byte  = 8'h00;
        if (rd_even_dec.hit) begin
            if (rd_even_dec.slot == 4'd0) begin
                case (rd_even_dec.off)
                    8'd0:    rd_even_byte = enable16[7:0];
                    8'd2:    rd_even_byte = pend16[7:0];
                    8'd4:    rd_even_byte = vector16[7:0];
                    default: rd_even_byte = 8'h00;
                endcase
            end
            for (int s = 1; s < NUM_SLOTS; s++) begin
                if (rd_even_dec.slot == 4'(s)) rd_even_byte = bus.slot_rd_even[8*s +: 8];
            end
        end
        if (rd_odd_dec.hit) begin
            if (rd_odd_dec.slot == 4'd0) begin
                case (rd_odd_dec.off)
                    8'd0:    rd_odd_byte = enable16[15:8];
                    8'd2:    rd_odd_byte = pend16[15:8];
                    8'd4:    rd_odd_byte = vector16[15:8];
                    default: rd_odd_byte = 8'h00;
                endcase
            end
            for (int s = 1; s < NUM_SLOTS; s++) begin
                if (rd_odd_dec.slot == 4'(s)) rd_odd_byte = bus.slot_rd_odd[8*s +: 8];
            end
        end
        if (wr_even_en && (wr_even_addr == rd_even_addr)) rd_even_byte = wr_even_byte;
        if (wr_odd_en && (wr_odd_addr == rd_odd_addr))    rd_odd_byte  = wr_odd_byte;
        dread_data_d = bus.dread_addr[0] ? {rd_even_byte, rd_odd_byte}
                                         : {rd_odd_byte, rd_even_byte};
    end

    // All fabric state; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dread_data_q <= '0;
            enable_q     <= '0;
            pending_q    <= '0;
            irq_prev_q   <= '0;
            armed_q      <= 1'b0;
            interrupt_q  <= 1'b0;
        end else begin
            dread_data_q <= dread_data_d;
            enable_q     <= enable_d;
            pending_q    <= pending_d;
            irq_prev_q   <= irq_prev_d;
            armed_q      <= armed_d;
            interrupt_q  <= interrupt_d;
        end
    end

    assign bus.dread_data = dread_data_q;
    assign bus.interrupt  = interrupt_q;
endmodule
